// File: rtl/sync_pattern_detector_pkg.sv
// Shared types for the parametrised KJ..KK sync pattern detector.
package sync_pattern_detector_pkg;

  localparam int unsigned PcntW = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExpJ = 2'd1,
    StExpK = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SymBad = 2'd0,
    SymK   = 2'd1,
    SymJ   = 2'd2
  } sym_e;

  // k=j=1, k=j=0 and unqualified cycles all collapse to SymBad.
  function automatic sym_e decode_sym(input logic k, input logic j, input logic rx_en);
    if (rx_en && k && !j) begin
      return SymK;
    end else if (rx_en && j && !k) begin
      return SymJ;
    end else begin
      return SymBad;
    end
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear together with inc loads 1.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = inc ? W'(1) : '0;
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/sync_pattern_detector.sv
// Detects N KJ pairs followed by KK (MIN_PAIRS <= N <= MAX_PAIRS) on the line-state symbols.
module sync_pattern_detector
  import sync_pattern_detector_pkg::*;
#(
  parameter int unsigned MIN_PAIRS = 2,
  parameter int unsigned MAX_PAIRS = 3,
  parameter bit          RESYNC    = 1'b0,
  parameter int unsigned ERR_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             k,
  input  logic             j,
  input  logic             rx_en,
  input  logic             clr_err,
  output logic             synced,
  output logic             sync_err,
  output logic [PcntW-1:0] sync_pairs,
  output logic             busy,
  output logic [ERR_W-1:0] err_cnt
);

  localparam logic [PcntW-1:0] MinP = PcntW'(MIN_PAIRS);
  localparam logic [PcntW-1:0] MaxP = PcntW'(MAX_PAIRS);

  state_e           state_q, state_d;
  logic [PcntW-1:0] pcnt_q, pcnt_d;
  logic             done_d, err_d;
  logic             synced_q, sync_err_q;
  logic [PcntW-1:0] sync_pairs_q;
  sym_e             sym;

  assign sym = decode_sym(k, j, rx_en);

  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (sym == SymK) begin
          state_d = StExpJ;
          pcnt_d  = '0;
        end
      end
      StExpJ: begin
        if ((sym == SymJ) && (pcnt_q < MaxP)) begin
          state_d = StExpK;
          pcnt_d  = pcnt_q + PcntW'(1);
        end else if ((sym == SymK) && (pcnt_q >= MinP)) begin
          // Closing K ends the pattern; it never seeds the next one.
          done_d  = 1'b1;
          state_d = StIdle;
        end else begin
          err_d = 1'b1;
        end
      end
      StExpK: begin
        if (sym == SymK) begin
          state_d = StExpJ;
        end else begin
          err_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (err_d) begin
      if (RESYNC && (sym == SymK)) begin
        state_d = StExpJ;
        pcnt_d  = '0;
      end else begin
        state_d = StIdle;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      pcnt_q       <= '0;
      synced_q     <= 1'b0;
      sync_err_q   <= 1'b0;
      sync_pairs_q <= '0;
    end else begin
      state_q    <= state_d;
      pcnt_q     <= pcnt_d;
      synced_q   <= done_d;
      sync_err_q <= err_d;
      if (done_d) begin
        sync_pairs_q <= pcnt_q;
      end
    end
  end

  sat_counter #(
    .W(ERR_W)
  ) u_err_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (err_d),
    .clr  (clr_err),
    .count(err_cnt)
  );

  assign synced     = synced_q;
  assign sync_err   = sync_err_q;
  assign sync_pairs = sync_pairs_q;
  assign busy       = (state_q != StIdle);

endmodule
